// File: rtl/sram_serial_slave_ctrl_pkg.sv
// Shared definitions for the SRAM serial slave: frame geometry, link mode
// encodings and the controller state encoding.
package sram_serial_slave_ctrl_pkg;

  localparam int MEMORY_DATA_WIDTH = 8;
  localparam int MEMORY_ADDR_WIDTH = 9;
  localparam int FRAME_WIDTH       = MEMORY_ADDR_WIDTH + MEMORY_DATA_WIDTH;
  localparam int COUNT_WIDTH       = $clog2(FRAME_WIDTH + 1);

  typedef enum logic [1:0] {
    MODE_RUN   = 2'b00,
    MODE_WRITE = 2'b01,
    MODE_READ  = 2'b10,
    MODE_NOP   = 2'b11
  } mode_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SHIFT   = 3'd1,
    ST_WRITE   = 3'd2,
    ST_VERIFY  = 3'd3,
    ST_VCHECK  = 3'd4,
    ST_READ    = 3'd5,
    ST_CAPTURE = 3'd6,
    ST_RUN     = 3'd7
  } state_t;

endpackage

// File: rtl/sram_serial_slave_ctrl_shifter.sv
// serial_frame_shifter: receive and transmit shift registers for one
// {addr, data} frame plus the bit counter that tells when it is complete.
// Both registers shift right: the first received bit ends up in bit 0 and
// the transmit register presents its bit 0 on the serial output.
module serial_frame_shifter
  import sram_serial_slave_ctrl_pkg::*;
(
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_load,
  input  logic                   i_shift,
  input  logic                   i_si,
  input  logic [FRAME_WIDTH-1:0] i_txData,
  output logic [FRAME_WIDTH-1:0] o_rxFrame,
  output logic                   o_frameDone,
  output logic                   o_so
);

  logic [FRAME_WIDTH-1:0] r_rx;
  logic [FRAME_WIDTH-1:0] r_tx;
  logic [COUNT_WIDTH-1:0] r_count;

  // Load the response and arm the counter on the load edge, then shift one bit per frame edge
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rx    <= '0;
      r_tx    <= '0;
      r_count <= '0;
    end else if (i_load) begin
      r_tx    <= i_txData;
      r_count <= COUNT_WIDTH'(FRAME_WIDTH);
    end else if (i_shift && (r_count != '0)) begin
      r_rx    <= {i_si, r_rx[FRAME_WIDTH-1:1]};
      r_tx    <= {1'b0, r_tx[FRAME_WIDTH-1:1]};
      r_count <= r_count - 1'b1;
    end
  end

  assign o_rxFrame   = r_rx;
  assign o_so        = r_tx[0];
  assign o_frameDone = i_shift && (r_count == COUNT_WIDTH'(1));

endmodule

// File: rtl/sram_serial_slave_ctrl.sv
// sram_serial_slave_ctrl: serial slave that turns 17-bit {addr, data} frames
// into SRAM writes/reads, streams back {last_addr, rd_data}, and lends the
// SRAM port to the SCPU in run mode.
// Optional feature macro: SRAM_SERIAL_WR_VERIFY_EN (read-back verify after
// each write with a sticky mismatch flag).
module sram_serial_slave_ctrl
  import sram_serial_slave_ctrl_pkg::*;
(
  input  logic                         csi_clk,
  input  logic                         rsi_reset,
  input  logic                         ctrl_bgn,
  input  logic                         ctrl_mod0,
  input  logic                         ctrl_mod1,
  input  logic                         ctrl_load,
  input  logic                         ctrl_si,
  output logic                         ctrl_so,
  output logic                         ctrl_rdy,
  output logic [MEMORY_ADDR_WIDTH-1:0] sram_addr,
  output logic [MEMORY_DATA_WIDTH-1:0] sram_wdata,
  output logic                         sram_we,
  output logic                         sram_re,
  input  logic [MEMORY_DATA_WIDTH-1:0] sram_rdata,
  input  logic [MEMORY_ADDR_WIDTH-1:0] cpu_addr,
  input  logic [MEMORY_DATA_WIDTH-1:0] cpu_wdata,
  input  logic                         cpu_we,
  input  logic                         cpu_re,
  output logic                         cpu_start,
  input  logic                         cpu_done,
  output logic                         verify_err
);

  state_t                       r_state;
  state_t                       w_nextState;
  mode_t                        r_mode;
  mode_t                        w_modePins;
  logic [MEMORY_ADDR_WIDTH-1:0] r_lastAddr;
  logic [MEMORY_DATA_WIDTH-1:0] r_lastWdata;
  logic [MEMORY_DATA_WIDTH-1:0] r_rdData;
  logic                         r_bgnPrev;
  logic                         r_cpuStart;
  logic                         w_bgnRise;
  logic                         w_startRun;
  logic                         w_load;
  logic                         w_shift;
  logic                         w_frameDone;
  logic [FRAME_WIDTH-1:0]       w_rxFrame;
  logic [MEMORY_ADDR_WIDTH-1:0] w_rxAddr;
  logic [MEMORY_DATA_WIDTH-1:0] w_rxData;

  assign w_modePins = mode_t'({ctrl_mod1, ctrl_mod0});
  assign w_bgnRise  = ctrl_bgn && !r_bgnPrev;
  assign w_load     = (r_state == ST_IDLE) && ctrl_load;
  assign w_shift    = (r_state == ST_SHIFT);
  assign w_rxAddr   = w_rxFrame[FRAME_WIDTH-1:MEMORY_DATA_WIDTH];
  assign w_rxData   = w_rxFrame[MEMORY_DATA_WIDTH-1:0];

  serial_frame_shifter u_shifter (
    .i_clk       (csi_clk),
    .i_rst       (rsi_reset),
    .i_load      (w_load),
    .i_shift     (w_shift),
    .i_si        (ctrl_si),
    .i_txData    ({r_lastAddr, r_rdData}),
    .o_rxFrame   (w_rxFrame),
    .o_frameDone (w_frameDone),
    .o_so        (ctrl_so)
  );

  // State register
  always_ff @(posedge csi_clk or posedge rsi_reset) begin
    if (rsi_reset) r_state <= ST_IDLE;
    else           r_state <= w_nextState;
  end

  // Next-state logic; a load in IDLE takes priority over a start request
  always_comb begin
    w_nextState = r_state;
    w_startRun  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (ctrl_load) begin
          w_nextState = ST_SHIFT;
        end else if ((w_modePins == MODE_RUN) && w_bgnRise) begin
          w_nextState = ST_RUN;
          w_startRun  = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (w_frameDone) begin
          case (r_mode)
            MODE_WRITE: w_nextState = ST_WRITE;
            MODE_READ:  w_nextState = ST_READ;
            default:    w_nextState = ST_IDLE;
          endcase
        end
      end
`ifdef SRAM_SERIAL_WR_VERIFY_EN
      ST_WRITE:   w_nextState = ST_VERIFY;
`else
      ST_WRITE:   w_nextState = ST_IDLE;
`endif
      ST_VERIFY:  w_nextState = ST_VCHECK;
      ST_VCHECK:  w_nextState = ST_IDLE;
      ST_READ:    w_nextState = ST_CAPTURE;
      ST_CAPTURE: w_nextState = ST_IDLE;
      ST_RUN:     if (cpu_done) w_nextState = ST_IDLE;
      default:    w_nextState = ST_IDLE;
    endcase
  end

  // SRAM port drive: frame contents during accesses, SCPU in run, held address/data otherwise
  always_comb begin
    ctrl_rdy   = (r_state == ST_IDLE);
    sram_addr  = r_lastAddr;
    sram_wdata = r_lastWdata;
    sram_we    = 1'b0;
    sram_re    = 1'b0;
    case (r_state)
      ST_WRITE: begin
        sram_addr  = w_rxAddr;
        sram_wdata = w_rxData;
        sram_we    = 1'b1;
      end
      ST_READ: begin
        sram_addr = w_rxAddr;
        sram_re   = 1'b1;
      end
      ST_VERIFY: begin
        sram_re = 1'b1;
      end
      ST_RUN: begin
        sram_addr  = cpu_addr;
        sram_wdata = cpu_wdata;
        sram_we    = cpu_we;
        sram_re    = cpu_re;
      end
      default: begin
      end
    endcase
  end

  // Frame mode, last access address/data, read capture and start-pulse generation
  always_ff @(posedge csi_clk or posedge rsi_reset) begin
    if (rsi_reset) begin
      r_mode      <= MODE_RUN;
      r_lastAddr  <= '0;
      r_lastWdata <= '0;
      r_rdData    <= '0;
      r_bgnPrev   <= 1'b0;
      r_cpuStart  <= 1'b0;
    end else begin
      r_bgnPrev  <= ctrl_bgn;
      r_cpuStart <= w_startRun;
      if (w_load) r_mode <= w_modePins;
      if (r_state == ST_WRITE) begin
        r_lastAddr  <= w_rxAddr;
        r_lastWdata <= w_rxData;
      end
      if (r_state == ST_READ) r_lastAddr <= w_rxAddr;
      if (r_state == ST_CAPTURE) r_rdData <= sram_rdata;
    end
  end

  assign cpu_start = r_cpuStart;

`ifdef SRAM_SERIAL_WR_VERIFY_EN
  logic r_verifyErr;

  // Sticky flag: read-back data differs from what was just written
  always_ff @(posedge csi_clk or posedge rsi_reset) begin
    if (rsi_reset) begin
      r_verifyErr <= 1'b0;
    end else if ((r_state == ST_VCHECK) && (sram_rdata != r_lastWdata)) begin
      r_verifyErr <= 1'b1;
    end
  end

  assign verify_err = r_verifyErr;
`else
  assign verify_err = 1'b0;
`endif

endmodule
